// File: rtl/systolic_array_arbiter.sv
// Round-robin front end that shares one pipelined 2x2 systolic array among NUM_REQ requesters.
// Each issued job's requester ID rides a tag FIFO so in-order array results route back to their owner.
module systolic_array_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int MAX_OUT = 8,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*16-1:0]      req_a,
    input  logic [NUM_REQ*16-1:0]      req_b,
    output logic                       sa_in_valid,
    output logic [15:0]                sa_a,
    output logic [15:0]                sa_b,
    input  logic [35:0]                sa_c,
    input  logic                       sa_out_valid,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [35:0]                rsp_c,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       err_spurious
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ID_W:0]    NREQ    = (ID_W+1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_issueId;
    logic               r_saInValid;
    logic [15:0]        r_saA;
    logic [15:0]        r_saB;
    logic [CNT_W-1:0]   r_wrPtr;
    logic [CNT_W-1:0]   r_rdPtr;
    logic [ID_W-1:0]    r_tagMem [MAX_OUT];
    logic [NUM_REQ-1:0] r_rspValid;
    logic [35:0]        r_rspC;
    logic [CNT_W-1:0]   r_outstanding;
    logic               r_errSpurious;

    logic               w_eligible;
    logic               w_found;
    logic [ID_W-1:0]    w_grantId;
    logic [ID_W:0]      w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_fifoEmpty;
    logic               w_pop;
    logic [ID_W-1:0]    w_headId;
    logic [NUM_REQ-1:0] w_headOneHot;
    logic [ID_W-1:0]    w_nextPtr;

    // The in-flight count includes the issue register, so gating grants on it keeps the FIFO from overflowing.
    assign w_eligible = (r_outstanding < MAX_CNT);

    always_comb begin
        w_found   = 1'b0;
        w_grantId = '0;
        w_idx     = '0;
        w_grant   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && w_eligible && req_valid[w_idx[ID_W-1:0]]) begin
                w_found   = 1'b1;
                w_grantId = w_idx[ID_W-1:0];
            end
        end
        if (w_found) begin
            w_grant[w_grantId] = 1'b1;
        end
    end

    assign w_nextPtr    = (w_grantId == ID_W'(NUM_REQ - 1)) ? '0 : w_grantId + ID_W'(1);
    assign w_fifoEmpty  = (r_wrPtr == r_rdPtr);
    assign w_pop        = sa_out_valid && !w_fifoEmpty;
    assign w_headId     = r_tagMem[r_rdPtr[PTR_W-1:0]];
    assign w_headOneHot = NUM_REQ'(1) << w_headId;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_issueId     <= '0;
            r_saInValid   <= 1'b0;
            r_saA         <= '0;
            r_saB         <= '0;
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_rspValid    <= '0;
            r_rspC        <= '0;
            r_outstanding <= '0;
            r_errSpurious <= 1'b0;
        end else begin
            r_saInValid <= w_found;
            if (w_found) begin
                r_ptr     <= w_nextPtr;
                r_issueId <= w_grantId;
                r_saA     <= req_a[int'(w_grantId)*16 +: 16];
                r_saB     <= req_b[int'(w_grantId)*16 +: 16];
            end

            // The tag is pushed as the job enters the array, not at the handshake.
            if (r_saInValid) begin
                r_wrPtr <= r_wrPtr + CNT_W'(1);
            end

            r_rspValid <= w_pop ? w_headOneHot : '0;
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + CNT_W'(1);
                r_rspC  <= sa_c;
            end

            if (sa_out_valid && w_fifoEmpty) begin
                r_errSpurious <= 1'b1;
            end

            unique case ({w_found, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Tag storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (r_saInValid) begin
            r_tagMem[r_wrPtr[PTR_W-1:0]] <= r_issueId;
        end
    end

    assign req_ready    = w_grant;
    assign sa_in_valid  = r_saInValid;
    assign sa_a         = r_saA;
    assign sa_b         = r_saB;
    assign rsp_valid    = r_rspValid;
    assign rsp_c        = r_rspC;
    assign outstanding  = r_outstanding;
    assign err_spurious = r_errSpurious;

endmodule

// File: tb/tb_systolic_array_arbiter.sv
// Directed bench for systolic_array_arbiter with a 3-stage stub array that can be switched to manual result injection.
module tb_systolic_array_arbiter;

    localparam int NUM_REQ = 2;
    localparam int MAX_OUT = 8;
    localparam logic [35:0] C1 = {9'd19, 9'd22, 9'd43, 9'd50};
    localparam logic [35:0] C2 = {9'd155, 9'd142, 9'd258, 9'd236};

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*16-1:0] req_a = '0;
    logic [NUM_REQ*16-1:0] req_b = '0;
    logic                 sa_in_valid;
    logic [15:0]          sa_a;
    logic [15:0]          sa_b;
    logic [35:0]          sa_c;
    logic                 sa_out_valid;
    logic [NUM_REQ-1:0]   rsp_valid;
    logic [35:0]          rsp_c;
    logic [3:0]           outstanding;
    logic                 err_spurious;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic        stubManual = 1'b0;
    logic        manVal = 1'b0;
    logic [35:0] manC = '0;
    logic [2:0]  pv;
    logic [35:0] pc [3];

    int          grantQ[$];
    logic [37:0] rspQ[$];
    int          issueCyc[$];
    int          rspCyc[$];

    systolic_array_arbiter #(.NUM_REQ(NUM_REQ), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .sa_in_valid(sa_in_valid), .sa_a(sa_a), .sa_b(sa_b),
        .sa_c(sa_c), .sa_out_valid(sa_out_valid),
        .rsp_valid(rsp_valid), .rsp_c(rsp_c),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [35:0] mul(input logic [15:0] a, input logic [15:0] b);
        logic [8:0] a11, a12, a21, a22, b11, b12, b21, b22;
        a11 = 9'(a[15:12]); a12 = 9'(a[11:8]); a21 = 9'(a[7:4]); a22 = 9'(a[3:0]);
        b11 = 9'(b[15:12]); b12 = 9'(b[11:8]); b21 = 9'(b[7:4]); b22 = 9'(b[3:0]);
        return {a11*b11 + a12*b21, a11*b12 + a12*b22, a21*b11 + a22*b21, a21*b12 + a22*b22};
    endfunction

    // Stub array: fixed three-cycle latency, sharing the arbiter's reset.
    always @(posedge clk) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], sa_in_valid};
            pc[0] <= mul(sa_a, sa_b);
            pc[1] <= pc[0];
            pc[2] <= pc[1];
        end
    end

    assign sa_out_valid = stubManual ? manVal : pv[2];
    assign sa_c         = stubManual ? manC : pc[2];

    // Event log sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) grantQ.push_back(i);
            end
            if (sa_in_valid) issueCyc.push_back(cyc);
            if (rsp_valid != '0) begin
                rspQ.push_back({rsp_valid, rsp_c});
                rspCyc.push_back(cyc);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [15:0] a0, input logic [15:0] b0,
                                 input logic [15:0] a1, input logic [15:0] b1);
        req_valid = valid;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
    endtask

    task automatic clearLogs();
        grantQ.delete();
        rspQ.delete();
        issueCyc.delete();
        rspCyc.delete();
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        req_valid = '0;
        manVal    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        clearLogs();
    endtask

    task automatic waitRsp();
        for (int n = 0; n < 20 && rsp_valid == '0; n++) step();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting");
        doReset();
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_sa_in_valid", sa_in_valid, 0);
        checkOutput("rst_sa_a", sa_a, 0);
        checkOutput("rst_sa_b", sa_b, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_c", rsp_c, 0);
        checkOutput("rst_outstanding", outstanding, 0);
        checkOutput("rst_err", err_spurious, 0);

        // Single job from requester 0
        applyStimulus(2'b01, 16'h1234, 16'h5678, 16'h0000, 16'h0000);
        #1;
        checkOutput("single_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        checkOutput("single_in_valid", sa_in_valid, 1);
        checkOutput("single_sa_a", sa_a, 16'h1234);
        checkOutput("single_sa_b", sa_b, 16'h5678);
        checkOutput("single_outst1", outstanding, 1);
        step();
        checkOutput("single_in_valid_low", sa_in_valid, 0);
        checkOutput("single_sa_a_hold", sa_a, 16'h1234);
        waitRsp();
        checkOutput("single_rsp_valid", rsp_valid, 2'b01);
        checkOutput("single_rsp_c", rsp_c, C1);
        checkOutput("single_outst0", outstanding, 0);

        // Contention: both requesters hold valid
        doReset();
        applyStimulus(2'b11, 16'h1234, 16'h5678, 16'h678E, 16'hDCBA);
        repeat (4) step();
        req_valid = '0;
        for (int n = 0; n < 30 && rspQ.size() < 4; n++) step();
        checkOutput("cont_grant_count", grantQ.size(), 4);
        checkOutput("cont_rsp_count", rspQ.size(), 4);
        for (int i = 0; i < 4 && i < grantQ.size(); i++) begin
            checkOutput($sformatf("cont_grant%0d", i), grantQ[i], i % 2);
        end
        for (int i = 0; i < 4 && i < rspQ.size(); i++) begin
            checkOutput($sformatf("cont_rsp%0d", i), rspQ[i], (i % 2 == 0) ? {2'b01, C1} : {2'b10, C2});
        end

        // Back-to-back from requester 1
        doReset();
        applyStimulus(2'b10, 16'h0000, 16'h0000, 16'h678E, 16'hDCBA);
        #1;
        checkOutput("b2b_ready", req_ready, 2'b10);
        step();
        step();
        req_valid = '0;
        for (int n = 0; n < 20 && rspQ.size() < 2; n++) step();
        checkOutput("b2b_issue_count", issueCyc.size(), 2);
        checkOutput("b2b_rsp_count", rspQ.size(), 2);
        if (issueCyc.size() == 2) checkOutput("b2b_issue_gap", issueCyc[1] - issueCyc[0], 1);
        if (rspQ.size() == 2) begin
            checkOutput("b2b_rsp_gap", rspCyc[1] - rspCyc[0], 1);
            checkOutput("b2b_rsp0", rspQ[0], {2'b10, C2});
            checkOutput("b2b_rsp1", rspQ[1], {2'b10, C2});
        end

        // Full: array held silent while MAX_OUT jobs are issued
        doReset();
        stubManual = 1'b1;
        applyStimulus(2'b01, 16'h1111, 16'h2222, 16'h0000, 16'h0000);
        repeat (8) step();
        checkOutput("full_outst8", outstanding, 8);
        #1;
        checkOutput("full_ready0", req_ready, 0);
        step();
        step();
        checkOutput("full_outst_hold", outstanding, 8);
        checkOutput("full_grant_count", grantQ.size(), 8);
        manVal = 1'b1;
        manC   = 36'h123456789;
        #1;
        checkOutput("full_ready_at_pop", req_ready, 0);
        step();
        manVal = 1'b0;
        #1;
        checkOutput("full_outst7", outstanding, 7);
        checkOutput("full_ready_after_pop", req_ready, 2'b01);
        checkOutput("full_rsp_valid", rsp_valid, 2'b01);
        checkOutput("full_rsp_c", rsp_c, 36'h123456789);
        manVal = 1'b1;
        manC   = 36'h0ABCDEF01;
        step();
        manVal = 1'b0;
        checkOutput("full_pop_and_push", outstanding, 7);
        checkOutput("full_grant_count9", grantQ.size(), 9);
        checkOutput("full_rsp_c2", rsp_c, 36'h0ABCDEF01);
        step();
        checkOutput("full_outst8_again", outstanding, 8);
        checkOutput("full_grant_count10", grantQ.size(), 10);
        #1;
        checkOutput("full_ready0_again", req_ready, 0);
        req_valid = '0;

        // Spurious result with nothing outstanding
        doReset();
        manVal = 1'b1;
        manC   = 36'hFFFFFFFFF;
        step();
        manVal = 1'b0;
        checkOutput("spur_err", err_spurious, 1);
        checkOutput("spur_outst", outstanding, 0);
        step();
        checkOutput("spur_rsp_valid", rsp_valid, 0);
        repeat (3) step();
        checkOutput("spur_err_sticky", err_spurious, 1);
        checkOutput("spur_no_rsp", rspQ.size(), 0);
        doReset();
        checkOutput("spur_err_cleared", err_spurious, 0);

        // Reset in the middle of three in-flight jobs
        stubManual = 1'b0;
        applyStimulus(2'b11, 16'h1234, 16'h5678, 16'h678E, 16'hDCBA);
        repeat (3) step();
        checkOutput("midrst_outst3", outstanding, 3);
        req_valid = '0;
        rst_n     = 1'b0;
        step();
        checkOutput("midrst_in_valid", sa_in_valid, 0);
        checkOutput("midrst_sa_a", sa_a, 0);
        checkOutput("midrst_sa_b", sa_b, 0);
        checkOutput("midrst_rsp_valid", rsp_valid, 0);
        checkOutput("midrst_outst", outstanding, 0);
        rst_n = 1'b1;
        clearLogs();
        repeat (10) step();
        checkOutput("midrst_no_rsp", rspQ.size(), 0);
        checkOutput("midrst_outst_after", outstanding, 0);
        applyStimulus(2'b11, 16'h1234, 16'h5678, 16'h678E, 16'hDCBA);
        #1;
        checkOutput("midrst_ptr0", req_ready, 2'b01);
        req_valid = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
